// File: rtl/decode_stage_controller_pkg.sv
// Shared core definitions: RV32 base opcodes and the immediate-format encoding
// used by both the decode controller and the immediate extender.
package decode_stage_controller_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [2:0] {
        IMM_I     = 3'b000,
        IMM_S     = 3'b001,
        IMM_B     = 3'b010,
        IMM_U     = 3'b011,
        IMM_J     = 3'b100,
        IMM_SHAMT = 3'b101
    } imm_src_t;

endpackage

// File: rtl/decode_stage_controller_imm_src_decoder.sv
// Purely combinational opcode classifier: immediate format, whether the
// instruction consumes an immediate, and whether the opcode is outside RV32I.
module imm_src_decoder
    import decode_stage_controller_pkg::*;
(
    input  logic [31:0] instr,
    output imm_src_t    imm_src,
    output logic        uses_imm,
    output logic        illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       unused_fields;

    assign opcode        = instr[6:0];
    assign funct3        = instr[14:12];
    assign unused_fields = ^{instr[31:15], instr[11:7]};

    always_comb begin
        imm_src  = IMM_I;
        uses_imm = 1'b0;
        illegal  = 1'b0;
        case (opcode)
            OP_LOAD, OP_JALR: begin
                imm_src  = IMM_I;
                uses_imm = 1'b1;
            end
            OP_IMM: begin
                // slli/srli/srai carry a 5-bit shift amount instead of a 12-bit immediate
                imm_src  = (funct3 == 3'b001 || funct3 == 3'b101) ? IMM_SHAMT : IMM_I;
                uses_imm = 1'b1;
            end
            OP_STORE: begin
                imm_src  = IMM_S;
                uses_imm = 1'b1;
            end
            OP_BRANCH: begin
                imm_src  = IMM_B;
                uses_imm = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                imm_src  = IMM_U;
                uses_imm = 1'b1;
            end
            OP_JAL: begin
                imm_src  = IMM_J;
                uses_imm = 1'b1;
            end
            OP_OP, OP_FENCE, OP_SYSTEM: begin
                imm_src  = IMM_I;
                uses_imm = 1'b0;
            end
            default: begin
                imm_src  = IMM_I;
                uses_imm = 1'b0;
                illegal  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/decode_stage_controller.sv
// Decode stage: owns the IF/ID and ID/EX pipeline registers and steers the
// external immediate extender through imm_src_d / imm_d.
module decode_stage_controller
    import decode_stage_controller_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_f,
    input  logic [31:0] pc_f,
    input  logic        valid_f,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic        flush_e,
    output logic        ready_f,
    output logic [31:0] instr_d,
    output logic [2:0]  imm_src_d,
    input  logic [31:0] imm_d,
    output logic        valid_e,
    output logic [31:0] pc_e,
    output logic [31:0] imm_e,
    output logic [4:0]  rs1_e,
    output logic [4:0]  rs2_e,
    output logic [4:0]  rd_e,
    output logic        uses_imm_e,
    output logic        illegal_e
);

    // Fetch handshake: an instruction transfers into IF/ID on any edge where
    // valid_f && ready_f; ready_f is low exactly while the hazard unit stalls D.
    assign ready_f = !stall_d;

    logic [31:0] pc_d;
    logic        valid_d;
    imm_src_t    imm_src;
    logic        uses_imm_d;
    logic        opcode_illegal;
    logic        illegal_d;
    logic        no_rd_d;

    imm_src_decoder u_imm_src_decoder (
        .instr    (instr_d),
        .imm_src  (imm_src),
        .uses_imm (uses_imm_d),
        .illegal  (opcode_illegal)
    );

    assign imm_src_d = imm_src;
    assign illegal_d = valid_d && opcode_illegal;
    // Stores and branches have no destination; illegal ops must not write back
    assign no_rd_d   = illegal_d || (instr_d[6:0] == OP_STORE) || (instr_d[6:0] == OP_BRANCH);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_d <= 1'b0;
            instr_d <= NOP_INSTR;
            pc_d    <= 32'h0;
        end else if (flush_d) begin
            valid_d <= 1'b0;
            instr_d <= NOP_INSTR;
        end else if (!stall_d) begin
            valid_d <= valid_f;
            instr_d <= instr_f;
            pc_d    <= pc_f;
        end
    end

    // An invalid D slot moves into E as a bubble, identical to a stall or flush
    always_ff @(posedge clk) begin
        if (rst || flush_e || stall_d || !valid_d) begin
            valid_e    <= 1'b0;
            pc_e       <= 32'h0;
            imm_e      <= 32'h0;
            rs1_e      <= 5'd0;
            rs2_e      <= 5'd0;
            rd_e       <= 5'd0;
            uses_imm_e <= 1'b0;
            illegal_e  <= 1'b0;
        end else begin
            valid_e    <= 1'b1;
            pc_e       <= pc_d;
            imm_e      <= imm_d;
            rs1_e      <= instr_d[19:15];
            rs2_e      <= instr_d[24:20];
            rd_e       <= no_rd_d ? 5'd0 : instr_d[11:7];
            uses_imm_e <= uses_imm_d;
            illegal_e  <= illegal_d;
        end
    end

endmodule

// File: tb/tb_decode_stage_controller.sv
// Bench for decode_stage_controller: directed scenarios plus randomized traffic
// checked against a cycle-level reference model of the two pipeline slots.
module tb_decode_stage_controller;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_f, pc_f, imm_d;
    logic        valid_f, stall_d, flush_d, flush_e;
    logic        ready_f;
    logic [31:0] instr_d;
    logic [2:0]  imm_src_d;
    logic        valid_e;
    logic [31:0] pc_e, imm_e;
    logic [4:0]  rs1_e, rs2_e, rd_e;
    logic        uses_imm_e, illegal_e;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: D slot and packed E slot
    logic [31:0] m_instr_d, m_pc_d;
    logic        m_valid_d;
    logic [81:0] m_e;
    logic [81:0] obs_e;
    logic [2:0]  exp_q[$];

    assign obs_e = {valid_e, pc_e, imm_e, rs1_e, rs2_e, rd_e, uses_imm_e, illegal_e};

    always #5 clk = ~clk;

    decode_stage_controller dut (
        .clk        (clk),
        .rst        (rst),
        .instr_f    (instr_f),
        .pc_f       (pc_f),
        .valid_f    (valid_f),
        .stall_d    (stall_d),
        .flush_d    (flush_d),
        .flush_e    (flush_e),
        .ready_f    (ready_f),
        .instr_d    (instr_d),
        .imm_src_d  (imm_src_d),
        .imm_d      (imm_d),
        .valid_e    (valid_e),
        .pc_e       (pc_e),
        .imm_e      (imm_e),
        .rs1_e      (rs1_e),
        .rs2_e      (rs2_e),
        .rd_e       (rd_e),
        .uses_imm_e (uses_imm_e),
        .illegal_e  (illegal_e)
    );

    function automatic logic [2:0] ref_imm_src(input logic [31:0] i);
        logic [6:0] op;
        logic [2:0] f3;
        op = i[6:0];
        f3 = i[14:12];
        if (op == 7'b0100011) return 3'd1;
        if (op == 7'b1100011) return 3'd2;
        if (op == 7'b0110111 || op == 7'b0010111) return 3'd3;
        if (op == 7'b1101111) return 3'd4;
        if (op == 7'b0010011 && (f3 == 3'b001 || f3 == 3'b101)) return 3'd5;
        return 3'd0;
    endfunction

    function automatic logic ref_legal(input logic [6:0] op);
        logic [6:0] legal [11];
        legal = '{7'b0000011, 7'b0010011, 7'b0010111, 7'b0100011, 7'b0110011, 7'b0110111,
                  7'b1100011, 7'b1100111, 7'b1101111, 7'b0001111, 7'b1110011};
        foreach (legal[k]) if (legal[k] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic ref_uses_imm(input logic [6:0] op);
        if (!ref_legal(op)) return 1'b0;
        return !(op == 7'b0110011 || op == 7'b0001111 || op == 7'b1110011);
    endfunction

    // Drive one cycle of inputs at the falling edge, advance the model, sample after the rising edge
    task automatic step(input logic [31:0] i, input logic [31:0] p, input logic v,
                        input logic s, input logic fd, input logic fe,
                        input logic r, input logic [31:0] imm);
        logic       ill;
        logic [4:0] rd;
        @(negedge clk);
        instr_f = i; pc_f = p; valid_f = v; stall_d = s;
        flush_d = fd; flush_e = fe; rst = r; imm_d = imm;
        if (r) begin
            m_valid_d = 1'b0; m_instr_d = NOP; m_pc_d = 32'h0; m_e = '0;
        end else begin
            if (fe || s || !m_valid_d) begin
                m_e = '0;
            end else begin
                ill = !ref_legal(m_instr_d[6:0]);
                rd  = (ill || m_instr_d[6:0] == 7'b0100011 || m_instr_d[6:0] == 7'b1100011)
                      ? 5'd0 : m_instr_d[11:7];
                m_e = {1'b1, m_pc_d, imm, m_instr_d[19:15], m_instr_d[24:20], rd,
                       ref_uses_imm(m_instr_d[6:0]), ill};
            end
            if (fd) begin
                m_valid_d = 1'b0; m_instr_d = NOP;
            end else if (!s) begin
                m_valid_d = v; m_instr_d = i; m_pc_d = p;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        step(32'hDEADBEEF, 32'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h5);
        step(32'hDEADBEEF, 32'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h5);
        n_vec++;
        if (instr_d !== NOP) begin n_err++; $display("FAIL reset_instr_d got %h want %h", instr_d, NOP); end
        n_vec++;
        if (obs_e !== 82'h0) begin n_err++; $display("FAIL reset_e got %h want 0", obs_e); end
        n_vec++;
        if (imm_src_d !== 3'd0) begin n_err++; $display("FAIL reset_imm_src got %0d want 0", imm_src_d); end
    endtask

    task automatic test_addi;
        step(32'h00A00093, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        n_vec++;
        if (instr_d !== 32'h00A00093 || imm_src_d !== 3'd0) begin
            n_err++; $display("FAIL addi_d got %h/%0d want 00a00093/0", instr_d, imm_src_d);
        end
        step(NOP, 32'h104, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd10);
        n_vec++;
        if ({valid_e, imm_e, rd_e, uses_imm_e, pc_e} !== {1'b1, 32'd10, 5'd1, 1'b1, 32'h100}) begin
            n_err++;
            $display("FAIL addi_e got v=%b imm=%0d rd=%0d ui=%b pc=%h want v=1 imm=10 rd=1 ui=1 pc=100",
                     valid_e, imm_e, rd_e, uses_imm_e, pc_e);
        end
    endtask

    task automatic test_formats;
        logic [31:0] seq [5];
        logic [2:0]  want;
        seq = '{32'h00112623, 32'hFE000EE3, 32'h008000EF, 32'h123450B7, 32'h00309093};
        exp_q = '{3'd1, 3'd2, 3'd4, 3'd3, 3'd5};
        for (int k = 0; k < 5; k++) begin
            step(seq[k], 32'h200 + 32'(4 * k), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            want = exp_q.pop_front();
            n_vec++;
            if (imm_src_d !== want) begin
                n_err++; $display("FAIL fmt_imm_src[%0d] got %0d want %0d", k, imm_src_d, want);
            end
            if (k == 1 || k == 2) begin
                n_vec++;
                if (rd_e !== 5'd0 || valid_e !== 1'b1) begin
                    n_err++; $display("FAIL fmt_rd_e[%0d] got rd=%0d v=%b want rd=0 v=1", k, rd_e, valid_e);
                end
            end
        end
    endtask

    task automatic test_stall;
        step(32'h0040A183, 32'h300, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h4);
        for (int k = 0; k < 2; k++) begin
            step(32'h00000033, 32'h304, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h4);
            n_vec++;
            if (instr_d !== 32'h0040A183 || valid_e !== 1'b0 || ready_f !== 1'b0) begin
                n_err++;
                $display("FAIL stall_hold[%0d] got instr=%h ve=%b rdy=%b want 0040a183/0/0",
                         k, instr_d, valid_e, ready_f);
            end
        end
        step(32'h00000033, 32'h304, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h4);
        n_vec++;
        if (valid_e !== 1'b1 || pc_e !== 32'h300 || rd_e !== 5'd3 || imm_e !== 32'h4) begin
            n_err++; $display("FAIL stall_release got v=%b pc=%h rd=%0d want 1/300/3", valid_e, pc_e, rd_e);
        end
        step(NOP, 32'h308, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        n_vec++;
        if (pc_e !== 32'h304 || valid_e !== 1'b1) begin
            n_err++; $display("FAIL stall_once got pc=%h v=%b want 304/1", pc_e, valid_e);
        end
    endtask

    task automatic test_flush;
        step(32'h00500113, 32'h400, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h5);
        step(32'h00600193, 32'h404, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h5);
        n_vec++;
        if (instr_d !== NOP || valid_e !== 1'b0) begin
            n_err++; $display("FAIL flush_d got instr=%h ve=%b want %h/0", instr_d, valid_e, NOP);
        end
        step(NOP, 32'h408, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h5);
        n_vec++;
        if (obs_e !== 82'h0) begin n_err++; $display("FAIL flush_no_e got %h want 0", obs_e); end
    endtask

    task automatic test_illegal;
        step(32'h00000FFF, 32'h500, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        n_vec++;
        if (imm_src_d !== 3'd0) begin n_err++; $display("FAIL illegal_imm_src got %0d want 0", imm_src_d); end
        step(NOP, 32'h504, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        n_vec++;
        if (illegal_e !== 1'b1 || rd_e !== 5'd0 || valid_e !== 1'b1) begin
            n_err++; $display("FAIL illegal_e got ill=%b rd=%0d v=%b want 1/0/1", illegal_e, rd_e, valid_e);
        end
    endtask

    task automatic test_reset_mid;
        step(32'h00100093, 32'h600, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1);
        step(32'h00200113, 32'h604, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h2);
        step(32'h00300193, 32'h608, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h3);
        n_vec++;
        if (instr_d !== NOP || obs_e !== 82'h0) begin
            n_err++; $display("FAIL reset_mid got instr=%h e=%h want %h/0", instr_d, obs_e, NOP);
        end
        step(32'h00400213, 32'h60C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h4);
        n_vec++;
        if (instr_d !== 32'h00400213) begin
            n_err++; $display("FAIL reset_resume got %h want 00400213", instr_d);
        end
        step(NOP, 32'h610, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h4);
        n_vec++;
        if (pc_e !== 32'h60C || valid_e !== 1'b1) begin
            n_err++; $display("FAIL reset_resume_e got pc=%h v=%b want 60c/1", pc_e, valid_e);
        end
    endtask

    task automatic test_random;
        logic [6:0]  ops [13];
        logic [31:0] ins;
        ops = '{7'b0000011, 7'b0010011, 7'b0010111, 7'b0100011, 7'b0110011, 7'b0110111,
                7'b1100011, 7'b1100111, 7'b1101111, 7'b0001111, 7'b1110011, 7'b1111111, 7'b0000000};
        for (int k = 0; k < 400; k++) begin
            ins = {$urandom()} & 32'hFFFF_FF80;
            ins[6:0] = ops[$urandom_range(0, 12)];
            step(ins, $urandom(), ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 49) == 0), $urandom());
            n_vec++;
            if (instr_d !== m_instr_d || imm_src_d !== ref_imm_src(m_instr_d) || ready_f !== !stall_d) begin
                n_err++;
                $display("FAIL rand_d[%0d] got instr=%h src=%0d rdy=%b want %h/%0d/%b",
                         k, instr_d, imm_src_d, ready_f, m_instr_d, ref_imm_src(m_instr_d), !stall_d);
            end
            n_vec++;
            if (obs_e !== m_e) begin
                n_err++; $display("FAIL rand_e[%0d] got %h want %h", k, obs_e, m_e);
            end
        end
    endtask

    initial begin
        rst = 1'b1; instr_f = NOP; pc_f = 32'h0; valid_f = 1'b0;
        stall_d = 1'b0; flush_d = 1'b0; flush_e = 1'b0; imm_d = 32'h0;
        m_instr_d = NOP; m_pc_d = 32'h0; m_valid_d = 1'b0; m_e = '0;
        test_reset();
        test_addi();
        test_formats();
        test_stall();
        test_flush();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/decode_stage_controller.md
DECODE_STAGE_CONTROLLER -- requirements
Module: decode_stage_controller

Interface
REQ-001 Clock and reset are decided: one clock, clk; reset is rst, synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 instr_f  input  32  fetched instruction.
REQ-005 pc_f  input  32  PC of instr_f.
REQ-006 valid_f  input  1  instr_f/pc_f valid this cycle.
REQ-007 stall_d  input  1  hazard unit holds the IF/ID register.
REQ-008 flush_d  input  1  kill the IF/ID contents (branch/jump taken).
REQ-009 flush_e  input  1  kill the ID/EX contents.
REQ-010 ready_f  output  1  fetch may advance; equals !stall_d.
REQ-011 instr_d  output  32  registered IF/ID instruction; drives the immediate extender instruction input.
REQ-012 imm_src_d  output  3  combinational immediate-format select for the extender.
REQ-013 imm_d  input  32  extender result for instr_d, same cycle.
REQ-014 valid_e, pc_e[32], imm_e[32], rs1_e[5], rs2_e[5], rd_e[5], uses_imm_e[1], illegal_e[1]  outputs  registered ID/EX fields.

Function
REQ-015 IF/ID update priority per edge: rst > flush_d > stall_d > load; load captures instr_f, pc_f, valid_f.
REQ-016 flush_d clears valid_d and loads instr_d = 32'h00000013 (NOP), pc unchanged; flush_d wins over a simultaneous stall_d.
REQ-017 stall_d holds instr_d, pc_d and valid_d unchanged.
REQ-018 imm_src_d decode on instr_d[6:0]: 0000011, 1100111, 0010011 with funct3 not 001/101 -> 000; 0100011 -> 001; 1100011 -> 010; 0110111, 0010111 -> 011; 1101111 -> 100; 0010011 with funct3 001/101 -> 101; all others -> 000.
REQ-019 uses_imm = 1 for every opcode in REQ-018 except 0110011 (R-type), 0001111 and 1110011, where it is 0.
REQ-020 Illegal = valid_d and opcode outside {0000011, 0010011, 0010111, 0100011, 0110011, 0110111, 1100011, 1100111, 1101111, 0001111, 1110011}.
REQ-021 ID/EX update priority per edge: rst > flush_e > stall_d (insert bubble) > load.
REQ-022 Bubble and flush_e both set valid_e=0, uses_imm_e=0, illegal_e=0, rd_e=0, and all other E fields to 0.
REQ-023 Load captures valid_e=valid_d, pc_e=pc_d, imm_e=imm_d, rs1_e=instr_d[19:15], rs2_e=instr_d[24:20], rd_e=instr_d[11:7], uses_imm_e, illegal_e.
REQ-024 rd_e is forced to 0 for opcodes 0100011 and 1100011 and for illegal instructions.
REQ-025 Latency: instruction present at instr_f on edge N appears at instr_d after N and at the E outputs after edge N+1, absent stalls.
REQ-026 valid_f=0 on load produces valid_d=0; E then receives a bubble per REQ-022 (valid_e=0).
REQ-027 Simultaneous stall_d and flush_e: E is cleared and D is held.

Reset
REQ-028 rst=1 at an edge forces valid_d=0, instr_d=32'h00000013, pc_d=0, and all E outputs to 0.
REQ-029 Reset mid-stall or mid-flush discards the held instruction; the first instruction accepted after reset is the one valid on the first edge with rst=0.

Structure
REQ-030 Opcode constants and the 3-bit imm_src enumeration (I, S, B, U, J, SHAMT) belong in the shared core package, and the extender uses the same encoding.
REQ-031 A single combinational sub-module, imm_src_decoder (instr -> imm_src, uses_imm, illegal), is instantiated; both pipeline registers remain in this module.

Verification
REQ-032 Scenario 1: load 32'h00A00093 (addi) -> imm_src_d=000; with imm_d=10, the next edge gives imm_e=10, rd_e=1, uses_imm_e=1, valid_e=1.
REQ-033 Scenario 2: sequence sw 32'h00112623, beq 32'hFE000EE3, jal 32'h008000EF, lui 32'h123450B7, slli 32'h00309093 -> imm_src_d 001, 010, 100, 011, 101 in consecutive cycles; rd_e=0 for sw and beq.
REQ-034 Scenario 3: stall_d for 2 cycles holding lw -> instr_d stays constant; valid_e=0 for 2 cycles, then the lw reaches E once.
REQ-035 Scenario 4: flush_d together with stall_d -> valid_d=0 and instr_d=32'h00000013 next cycle; no E entry for the killed instruction.
REQ-036 Scenario 5: opcode 1111111 valid -> illegal_e=1, rd_e=0, imm_src_d=000.
REQ-037 Scenario 6: rst asserted while a valid instruction sits in D and E -> all outputs 0 and instr_d=NOP after the edge; fetch resumes on the first edge with rst=0.
